// File: rtl/running_led_gen.sv
// Parametrised running-LED driver: bounce, centre fill, ring chase and ping-pong patterns with pause and wrap strobe.
// Optional step prescaler is compiled in with `define RUNNING_LED_PRESCALE_EN.
module running_led_gen #(
  parameter int LED_W = 12,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led_o,
  output logic             wrap_o
);

  localparam int H  = LED_W / 2;
  localparam int SW = $clog2(2 * LED_W - 2);

  localparam logic [1:0] M_BOUNCE   = 2'd0;
  localparam logic [1:0] M_FILL     = 2'd1;
  localparam logic [1:0] M_CHASE    = 2'd2;
  localparam logic [1:0] M_PINGPONG = 2'd3;

  logic [1:0]       mode_q, mode_nxt;
  logic [SW-1:0]    step, step_nxt;
  logic [LED_W-1:0] led_nxt;
  logic             wrap_nxt;
  logic             tick;
  logic             at_last;

  function automatic logic [LED_W-1:0] pattern(input logic [1:0] m, input logic [SW-1:0] k);
    logic [LED_W-1:0] v;
    int ki;
    int p;
    v  = '0;
    ki = int'(k);
    p  = 0;
    case (m)
      M_BOUNCE: begin
        p = (ki < H) ? ki : (2 * H - 2 - ki);
        for (int i = 0; i < LED_W; i++) v[i] = (i == p) || (i == LED_W - 1 - p);
      end
      M_FILL: begin
        for (int i = 0; i < LED_W; i++) v[i] = (ki >= 1) && (i >= H - ki) && (i <= H + ki - 1);
      end
      M_CHASE: begin
        for (int i = 0; i < LED_W; i++) v[i] = (i == ki);
      end
      default: begin
        p = (ki < LED_W) ? ki : (2 * LED_W - 2 - ki);
        for (int i = 0; i < LED_W; i++) v[i] = (i == p);
      end
    endcase
    return v;
  endfunction

  function automatic logic [SW-1:0] last_step(input logic [1:0] m);
    logic [SW-1:0] r;
    case (m)
      M_BOUNCE: r = SW'(2 * H - 3);
      M_FILL:   r = SW'(H);
      M_CHASE:  r = SW'(LED_W - 1);
      default:  r = SW'(2 * LED_W - 3);
    endcase
    return r;
  endfunction

  assign at_last = (step == last_step(mode_q));

`ifdef RUNNING_LED_PRESCALE_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre, pre_nxt;

  assign tick = en && (pre == PW'(DIV - 1));

  always_comb begin
    pre_nxt = pre;
    if (mode != mode_q || tick) pre_nxt = '0;
    else if (en)                pre_nxt = pre + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= pre_nxt;
  end
`else
  localparam int unused_div = DIV;

  assign tick = en;
`endif

  // Next state: a mode change outranks any tick and restarts the new pattern at step 0
  always_comb begin
    mode_nxt = mode_q;
    step_nxt = step;
    led_nxt  = led_o;
    wrap_nxt = 1'b0;
    if (mode != mode_q) begin
      mode_nxt = mode;
      step_nxt = '0;
      led_nxt  = pattern(mode, {SW{1'b0}});
    end else if (tick) begin
      step_nxt = at_last ? '0 : step + SW'(1);
      led_nxt  = pattern(mode_q, step_nxt);
      wrap_nxt = at_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_BOUNCE;
      step   <= '0;
      led_o  <= pattern(M_BOUNCE, {SW{1'b0}});
      wrap_o <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      step   <= step_nxt;
      led_o  <= led_nxt;
      wrap_o <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_running_led_gen.sv
// Directed table-driven bench for running_led_gen (LED_W=12); the prescaler sequence
// runs on a second LED_W=8, DIV=3 instance when RUNNING_LED_PRESCALE_EN is defined.
module tb_running_led_gen;

  typedef struct {
    logic [1:0]  mode;
    logic        en;
    logic [11:0] led;
    logic        wrap;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] led;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[$];

  running_led_gen #(.LED_W(12), .DIV(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .led_o  (led),
    .wrap_o (wrap)
  );

`ifdef RUNNING_LED_PRESCALE_EN
  logic       en2;
  logic [1:0] mode2;
  logic [7:0] led2;
  logic       wrap2;

  running_led_gen #(.LED_W(8), .DIV(3)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en2),
    .mode   (mode2),
    .led_o  (led2),
    .wrap_o (wrap2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic e, input logic [11:0] l, input logic w);
    vec_t v;
    v.mode = m;
    v.en   = e;
    v.led  = l;
    v.wrap = w;
    vecs.push_back(v);
  endtask

  task automatic cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] one;
    one = 12'h001;

`ifdef RUNNING_LED_PRESCALE_EN
    en2   = 1'b0;
    mode2 = 2'd0;
`endif

    // BOUNCE from reset, wrap lasts one cycle, then en=0 hold
    add(0, 1, 12'h402, 0); add(0, 1, 12'h204, 0); add(0, 1, 12'h108, 0);
    add(0, 1, 12'h090, 0); add(0, 1, 12'h060, 0); add(0, 1, 12'h090, 0);
    add(0, 1, 12'h108, 0); add(0, 1, 12'h204, 0); add(0, 1, 12'h402, 0);
    add(0, 1, 12'h801, 1); add(0, 1, 12'h402, 0);
    add(0, 0, 12'h402, 0); add(0, 0, 12'h402, 0);
    // FILL
    add(1, 1, 12'h000, 0); add(1, 1, 12'h060, 0); add(1, 1, 12'h0F0, 0);
    add(1, 1, 12'h1F8, 0); add(1, 1, 12'h3FC, 0); add(1, 1, 12'h7FE, 0);
    add(1, 1, 12'hFFF, 0); add(1, 1, 12'h000, 1); add(1, 1, 12'h060, 0);
    // PINGPONG for 5 ticks, then switch to CHASE with en=0
    add(3, 1, 12'h001, 0); add(3, 1, 12'h002, 0); add(3, 1, 12'h004, 0);
    add(3, 1, 12'h008, 0); add(3, 1, 12'h010, 0); add(3, 1, 12'h020, 0);
    add(2, 0, 12'h001, 0); add(2, 0, 12'h001, 0); add(2, 0, 12'h001, 0);
    // PINGPONG full period of 22
    add(3, 1, 12'h001, 0);
    for (int k = 1; k <= 11; k++) add(3, 1, one << k, 0);
    for (int k = 12; k <= 21; k++) add(3, 1, one << (22 - k), 0);
    add(3, 1, 12'h001, 1);
    add(3, 1, 12'h002, 0);

    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    #12;
    check("reset led", 32'(led), 32'h801);
    check("reset wrap", 32'(wrap), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      en   = vecs[i].en;
      cycle();
      check($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].led));
      check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].wrap));
    end

    // Asynchronous reset in the middle of CHASE
    mode = 2'd2;
    en   = 1'b1;
    cycle(); check("chase s0", 32'(led), 32'h001);
    cycle(); check("chase s1", 32'(led), 32'h002);
    cycle(); check("chase s2", 32'(led), 32'h004);
    cycle(); check("chase s3", 32'(led), 32'h008);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst led", 32'(led), 32'h801);
    check("async rst wrap", 32'(wrap), 32'h0);
    cycle();
    check("rst held led", 32'(led), 32'h801);
    rst_n = 1'b1;
    cycle(); check("restart s0 led", 32'(led), 32'h001);
    check("restart s0 wrap", 32'(wrap), 32'h0);
    cycle(); check("restart s1 led", 32'(led), 32'h002);

`ifdef RUNNING_LED_PRESCALE_EN
    begin
      logic       pen[15];
      logic [7:0] pexp[15];
      pen  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
      pexp = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04,
               8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h08, 8'h08};
      mode2 = 2'd2;
      for (int i = 0; i < 15; i++) begin
        en2 = pen[i];
        cycle();
        check($sformatf("pre%0d led", i), 32'(led2), 32'(pexp[i]));
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
